window_3x3_gen: RTL and testbench
=================================

# window_3x3_gen

Streaming 3×3 neighbourhood generator that sits directly downstream of the pixel line-storage stage in the preprocessing pipeline. It accepts a raster-ordered 24-bit RGB pixel stream, stores it in four rotating line memories, and emits one 3×3 window per cycle to the filter/convolution stage. Windows cover only fully interior positions; border pixels are not padded.

## Interface
- `W`, 240: pixels per line (W ≥ 4).
- `DW`, 24: bits per pixel (RGB888).
- `i_clk` input 1: clock; all logic on rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_valid` input 1: input pixel valid; accepted when `i_valid && o_ready`.
- `i_data` input DW: input pixel, raster order.
- `o_ready` output 1: upstream may write; combinational, `line_cnt != 4`.
- `o_valid` output 1: `o_window` holds a valid window this cycle.
- `o_window` output 9*DW: window; pixel (r,c) at `[DW*(3r+c) +: DW]`, r=0 oldest row, c=0 leftmost column.
- `o_last` output 1: qualifies the last window of an output row (with `o_valid`).

## Operation
- Storage: four line memories of W×DW, combinational read, synchronous write.
- Write side: `wr_col` (0..W-1), `wr_line` (0..3). Each accepted pixel writes `mem[wr_line][wr_col]`, `wr_col++`. At `wr_col == W-1`: `wr_col←0`, `wr_line←wr_line+1 mod 4`, line completes.
- `line_cnt` (0..4): completed, unretired lines. +1 on line completion, −1 on retire; both same cycle → unchanged.
- `rd_line` (0..3): oldest unretired line. Read rows = `rd_line`, `+1`, `+2` (mod 4).
- FSM, two states:
  - IDLE: `rd_col←0`. If `line_cnt ≥ 3` → READ next cycle.
  - READ: each cycle read column `rd_col` of the three rows, shift into window register (new column enters c=2, old columns shift toward c=0), `rd_col++`. At `rd_col == W-1`: retire (`rd_line+1 mod 4`, `line_cnt−1`) → IDLE.
- Output: `o_valid` registered; high the cycle after a read of column `rd_col ≥ 2`. `o_last` high with window containing columns W-3..W-1.
- Per burst exactly W-2 windows. Each retired line produces one output row; rows 0..H-3 for H input lines.
- Backpressure: `o_ready=0` only when `line_cnt==4` (writing would overwrite unread data). The write slot never aliases a read row.
- No downstream backpressure: consumer must accept every `o_valid` cycle.
- Reset mid-operation: all pointers, counters, FSM clear; partial lines discarded; memory contents not cleared.

## Timing
- Reset values: `o_valid=0`, `o_last=0`, `o_window=0`, `o_ready=1`, state IDLE, all counters 0.
- Line completion at edge k → `line_cnt` updated at k; if it reaches 3, FSM in READ at k+1.
- Burst: READ cycles t0..t(W-1) read columns 0..W-1; `o_valid` high t3..t(W), `o_last` at t(W).
- IDLE lasts ≥1 cycle between bursts; back-to-back bursts gap = 1 cycle when `line_cnt ≥ 3` at burst end (after retire).
- Latency: last pixel of 3rd line accepted at edge k → first window `o_valid` at cycle k+4.
- Write and read run concurrently; `o_ready` falls the cycle after 4th completion, rises the cycle after retire.

## Test plan
- W=8, stream 3 lines, pixel = {row,col} (`i_data = row*256+col`), continuous valid -> exactly 6 windows, first window rows 0..2 cols 0..2, `o_last` on window cols 5..7, `line_cnt` ends at 2.
- W=8, stream 10 lines continuous -> 8 output rows × 6 windows, each window row r = output row + r, `o_ready` never deasserts incorrectly, no data corruption across `rd_line` wrap 3→0.
- W=8, bursty `i_valid` (random 50%) over 6 lines -> identical window sequence to continuous case.
- Force fill: stream 5 lines at full rate while checking `o_ready` -> drops when `line_cnt==4`, rises cycle after retire; no pixel lost or overwritten.
- Line completion and retire in same cycle -> `line_cnt` unchanged, next burst starts after one IDLE cycle.
- Assert `i_rst` mid-burst (column 4 of line 5) -> next cycle `o_valid=0`, `o_ready=1`, counters 0; fresh 3 lines afterwards produce correct windows from new data only.

Source files
------------

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: raster pixels land in four rotating line memories,
// and each set of three stored lines is swept column by column into a 3x3 window register.
module window_3x3_gen #(
  parameter int unsigned W  = 240,
  parameter int unsigned DW = 24
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [DW-1:0]   i_data,
  output logic            o_ready,
  output logic            o_valid,
  output logic [9*DW-1:0] o_window,
  output logic            o_last
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] ColLast = CW'(W - 1);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  logic [DW-1:0] mem [4][W];
  logic [DW-1:0] win_q [3][3];
  logic [DW-1:0] col_pix [3];

  state_e        state_q;
  logic [CW-1:0] wr_col_q;
  logic [CW-1:0] rd_col_q;
  logic [1:0]    wr_line_q;
  logic [1:0]    rd_line_q;
  logic [2:0]    line_cnt_q;

  logic accept;
  logic line_done;
  logic retire;

  // Four lines stored means the write slot would land on the oldest unread line.
  assign o_ready   = (line_cnt_q != 3'd4);
  assign accept    = i_valid && o_ready;
  assign line_done = accept && (wr_col_q == ColLast);
  assign retire    = (state_q == StRead) && (rd_col_q == ColLast);

  always_ff @(posedge i_clk) begin
    if (accept && !i_rst) begin
      mem[wr_line_q][wr_col_q] <= i_data;
    end
  end

  // Row r of the window comes from line rd_line + r, wrapping over the four memories.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      col_pix[r] = mem[rd_line_q + 2'(r)][rd_col_q];
    end
  end

  always_comb begin
    o_window = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        o_window[DW*(3*r+c) +: DW] = win_q[r][c];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      wr_col_q   <= '0;
      rd_col_q   <= '0;
      wr_line_q  <= '0;
      rd_line_q  <= '0;
      line_cnt_q <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      if (accept) begin
        if (wr_col_q == ColLast) begin
          wr_col_q  <= '0;
          wr_line_q <= wr_line_q + 2'd1;
        end else begin
          wr_col_q <= wr_col_q + CW'(1);
        end
      end

      line_cnt_q <= line_cnt_q + 3'(line_done) - 3'(retire);
      o_valid    <= 1'b0;
      o_last     <= 1'b0;

      unique case (state_q)
        StIdle: begin
          rd_col_q <= '0;
          if (line_cnt_q >= 3'd3) begin
            state_q <= StRead;
          end
        end
        StRead: begin
          for (int r = 0; r < 3; r++) begin
            win_q[r][0] <= win_q[r][1];
            win_q[r][1] <= win_q[r][2];
            win_q[r][2] <= col_pix[r];
          end
          // The window is complete once three columns have been shifted in.
          o_valid <= (rd_col_q >= CW'(2));
          o_last  <= retire;
          if (retire) begin
            rd_col_q  <= '0;
            rd_line_q <= rd_line_q + 2'd1;
            state_q   <= StIdle;
          end else begin
            rd_col_q <= rd_col_q + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen with W=8: checks every emitted window against
// pixel = row*256 + col, plus reset, latency, backpressure and mid-burst reset behaviour.
module tb_window_3x3_gen;

  localparam int W  = 8;
  localparam int DW = 24;

  logic            clk;
  logic            rst;
  logic            i_valid;
  logic [DW-1:0]   i_data;
  logic            o_ready;
  logic            o_valid;
  logic [9*DW-1:0] o_window;
  logic            o_last;

  int checks;
  int passes;
  int lines_done;
  int row_base;
  int out_row;
  int win_idx;
  int win_count;
  bit ready_low_seen;

  window_3x3_gen #(
    .W  (W),
    .DW (DW)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_valid  (o_valid),
    .o_window (o_window),
    .o_last   (o_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [9*DW-1:0] exp_window(input int row0, input int col0);
    logic [9*DW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[DW*(3*r+c) +: DW] = DW'((row0 + r) * 256 + col0 + c);
      end
    end
    return w;
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_data     = '0;
    lines_done = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Holds one pixel until accepted; returns 1 ns after the accepting edge.
  task automatic push(input int row, input int col);
    int guard;
    guard   = 0;
    i_valid = 1'b1;
    i_data  = DW'(row * 256 + col);
    while (!o_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    if (col == W - 1) lines_done++;
  endtask

  task automatic send_line(input int row, input bit bursty);
    for (int c = 0; c < W; c++) begin
      if (bursty) begin
        while ($urandom_range(1) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      push(row, c);
    end
  endtask

  task automatic wait_windows(input string tag, input int n);
    int guard;
    guard = 0;
    while (win_count < n && guard < 600) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk(tag, win_count, n);
  endtask

  initial begin
    checks         = 0;
    passes         = 0;
    row_base       = 0;
    out_row        = 0;
    win_idx        = 0;
    win_count      = 0;
    ready_low_seen = 1'b0;

    // Window/last/ready monitor, sampled on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (rst) begin
          out_row   = 0;
          win_idx   = 0;
          win_count = 0;
        end else begin
          if (o_valid) begin
            chk("window", o_window, exp_window(row_base + out_row, win_idx));
            chk("o_last", o_last, (win_idx == W - 3));
            win_count++;
            if (win_idx == W - 3) begin
              win_idx = 0;
              out_row++;
            end else begin
              win_idx++;
            end
          end else begin
            chk("o_last_idle", o_last, 1'b0);
          end
          chk("o_ready", o_ready, ((lines_done - out_row) != 4));
          if (!o_ready) ready_low_seen = 1'b1;
        end
      end
    join_none

    // Reset values
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_o_last", o_last, 1'b0);
    chk("rst_o_window", o_window, '0);
    chk("rst_o_ready", o_ready, 1'b1);
    rst = 1'b0;

    // Three lines: six windows, first window four cycles after the last pixel
    lines_done = 0;
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("latency_low", o_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("latency_first", o_valid, 1'b1);
    wait_windows("three_line_count", 6);
    chk("three_line_cnt", dut.line_cnt_q, 2);

    // Ten continuous lines across the rd_line wrap
    do_reset();
    for (int r = 0; r < 10; r++) send_line(r, 1'b0);
    wait_windows("ten_line_count", 48);
    chk("ten_line_rows", out_row, 8);

    // Bursty input gives the same window sequence
    do_reset();
    for (int r = 0; r < 6; r++) send_line(r, 1'b1);
    wait_windows("bursty_count", 24);

    // Full-rate fill forces o_ready low at least once
    do_reset();
    ready_low_seen = 1'b0;
    for (int r = 0; r < 5; r++) send_line(r, 1'b0);
    wait_windows("fill_count", 18);
    chk("fill_ready_low", ready_low_seen, 1'b1);

    // Line completion on the retire edge: count holds, one IDLE cycle before next burst
    do_reset();
    for (int r = 0; r < 3; r++) send_line(r, 1'b0);
    @(posedge clk);
    #1;
    send_line(3, 1'b0);
    chk("coincide_last", o_last, 1'b1);
    chk("coincide_cnt", dut.line_cnt_q, 3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("coincide_gap", o_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    chk("coincide_next", o_valid, 1'b1);
    wait_windows("coincide_count", 12);

    // Reset at column 4 of line 5, then fresh data only
    do_reset();
    for (int r = 0; r < 5; r++) send_line(r, 1'b0);
    for (int c = 0; c < 4; c++) push(5, c);
    i_valid = 1'b1;
    i_data  = DW'(5 * 256 + 4);
    rst     = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_o_valid", o_valid, 1'b0);
    chk("midrst_o_ready", o_ready, 1'b1);
    chk("midrst_o_last", o_last, 1'b0);
    chk("midrst_o_window", o_window, '0);
    chk("midrst_cnt", dut.line_cnt_q, 0);
    i_valid    = 1'b0;
    lines_done = 0;
    row_base   = 16;
    rst        = 1'b0;
    for (int r = 16; r < 19; r++) send_line(r, 1'b0);
    wait_windows("midrst_count", 6);
    chk("midrst_rows", out_row, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
